// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and constants for the FIFO write arbiter
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  localparam int STAT_W     = 16;
  localparam int DEF_DATA_W = 8;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker, search starts just above last_idx
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_idx,
  output logic          any,
  output logic [IW-1:0] pick_idx,
  output logic [N-1:0]  pick_oh
);

  logic [IW-1:0] w_idx;

  // Walk the ring from farthest to nearest so the nearest valid requester wins.
  always_comb begin
    any      = 1'b0;
    pick_idx = '0;
    pick_oh  = '0;
    w_idx    = '0;
    for (int k = N; k >= 1; k--) begin
      w_idx = IW'((int'(last_idx) + k) % N);
      if (req[w_idx]) begin
        any      = 1'b1;
        pick_idx = w_idx;
      end
    end
    if (any) pick_oh[pick_idx] = 1'b1;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter driving the byte FIFO write port
// Optional per-requester beat counters on stat_cnt when FIFO_ARB_STATS_EN is defined.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = 8,
  parameter int IDX_W     = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_last,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      buf_full,
  output logic                      fifo_wr_en,
  output logic [DATA_W-1:0]         fifo_din,
  output logic [NUM_REQ-1:0]        grant_oh,
  output logic                      busy
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STAT_W-1:0] stat_cnt
`endif
);

  state_t               r_state;
  logic [NUM_REQ-1:0]   r_grant_oh;
  logic [IDX_W-1:0]     r_cur_idx;
  logic [IDX_W-1:0]     r_last_idx;
  logic [7:0]           r_burst_cnt;
  logic                 r_busy;

  logic                 w_any;
  logic [IDX_W-1:0]     w_pick_idx;
  logic [NUM_REQ-1:0]   w_pick_oh;
  logic                 w_in_burst;
  logic                 w_cur_valid;
  logic                 w_cur_last;
  logic                 w_accept;
  logic                 w_drop;
  logic [7:0]           w_cnt_next;
  logic                 w_burst_end;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IDX_W)
  ) u_pick (
    .req      (req_valid),
    .last_idx (r_last_idx),
    .any      (w_any),
    .pick_idx (w_pick_idx),
    .pick_oh  (w_pick_oh)
  );

  assign w_in_burst  = (r_state == ST_BURST);
  assign w_cur_valid = req_valid[r_cur_idx];
  assign w_cur_last  = req_last[r_cur_idx];
  assign w_accept    = w_in_burst & w_cur_valid & ~buf_full;
  // A valid drop only counts when the FIFO could have taken the beat.
  assign w_drop      = w_in_burst & ~w_cur_valid & ~buf_full;
  assign w_cnt_next  = r_burst_cnt + 8'd1;
  assign w_burst_end = w_accept & (w_cur_last | (w_cnt_next == 8'(MAX_BURST)));

  assign req_ready  = r_grant_oh & {NUM_REQ{~buf_full}};
  assign fifo_wr_en = w_accept;
  assign grant_oh   = r_grant_oh;
  assign busy       = r_busy;

  always_comb begin
    fifo_din = '0;
    if (w_in_burst) fifo_din = req_data[int'(r_cur_idx)*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_grant_oh  <= '0;
      r_cur_idx   <= '0;
      r_last_idx  <= IDX_W'(NUM_REQ - 1);
      r_burst_cnt <= 8'd0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any && !buf_full) begin
            r_grant_oh  <= w_pick_oh;
            r_cur_idx   <= w_pick_idx;
            r_burst_cnt <= 8'd0;
            r_busy      <= 1'b1;
            r_state     <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (w_accept) r_burst_cnt <= w_cnt_next;
          if (w_burst_end || w_drop) begin
            r_last_idx <= r_cur_idx;
            r_grant_oh <= '0;
            r_busy     <= 1'b0;
            r_state    <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [STAT_W-1:0] r_stat [NUM_REQ];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REQ; i++) r_stat[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_accept && (r_cur_idx == IDX_W'(i)) && (r_stat[i] != {STAT_W{1'b1}}))
          r_stat[i] <= r_stat[i] + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    assign stat_cnt[g*STAT_W +: STAT_W] = r_stat[g];
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - scoreboard bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;

  typedef struct packed {
    logic [3:0] oh;
    logic [7:0] data;
    logic [7:0] gap;
  } exp_t;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_last;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            buf_full;
  logic            fifo_wr_en;
  logic [DW-1:0]   fifo_din;
  logic [N-1:0]    grant_oh;
  logic            busy;
`ifdef FIFO_ARB_STATS_EN
  logic [N*16-1:0] stat_cnt;
`endif

  fifo_wr_arbiter #(
    .NUM_REQ   (N),
    .DATA_W    (DW),
    .MAX_BURST (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_last   (req_last),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .buf_full   (buf_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_din   (fifo_din),
    .grant_oh   (grant_oh),
    .busy       (busy)
`ifdef FIFO_ARB_STATS_EN
    ,
    .stat_cnt   (stat_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [8:0] pq [N][$];
  exp_t       eq [$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         n_wr = 0;
  int         cyc = 0;
  int         last_cyc = 0;
  logic [N-1:0] acc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic update_drv();
    logic [8:0] head;
    for (int i = 0; i < N; i++) begin
      if (pq[i].size() > 0) begin
        head = pq[i][0];
        req_valid[i]        = 1'b1;
        req_last[i]         = head[8];
        req_data[i*DW +: DW] = head[7:0];
      end else begin
        req_valid[i]        = 1'b0;
        req_last[i]         = 1'b0;
        req_data[i*DW +: DW] = '0;
      end
    end
  endtask

  task automatic load(input int r, input int n, input logic [7:0] base, input bit last_end);
    for (int k = 0; k < n; k++)
      pq[r].push_back({(last_end && (k == n - 1)), base + 8'(k)});
  endtask

  task automatic expect_run(input int r, input int n, input logic [7:0] base, input int first_gap);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.oh   = 4'(1 << r);
      e.data = base + 8'(k);
      e.gap  = (k == 0) ? 8'(first_gap) : 8'd1;
      eq.push_back(e);
    end
  endtask

  function automatic bit pending();
    bit p = (eq.size() != 0);
    for (int i = 0; i < N; i++) if (pq[i].size() != 0) p = 1'b1;
    return p;
  endfunction

  task automatic drain(input string name);
    int t = 0;
    while (pending() && t < 400) begin
      @(posedge clk);
      t++;
    end
    if (pending()) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_drain: %0d beats still expected after %0d cycles", name, eq.size(), t);
      eq.delete();
      for (int i = 0; i < N; i++) pq[i].delete();
      update_drv();
    end
    repeat (4) @(posedge clk);
  endtask

  task automatic wait_writes(input int target, input string name);
    int t = 0;
    do begin
      @(posedge clk);
      t++;
    end while (n_wr < target && t < 60);
    if (n_wr < target) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_wait: got %0d writes, expected %0d", name, n_wr, target);
    end
  endtask

  // Producer model: decide acceptance mid-cycle, retire beats just after the edge.
  initial begin
    forever begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      if (rst) for (int i = 0; i < N; i++) if (acc[i]) void'(pq[i].pop_front());
      update_drv();
    end
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: every FIFO write is matched against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (fifo_wr_en) begin
        n_wr++;
        if (eq.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL wr_unexpected: got data %0h grant %0b, expected no write", fifo_din, grant_oh);
        end else begin
          e = eq.pop_front();
          check("wr_data", 32'(fifo_din), 32'(e.data));
          check("wr_grant", 32'(grant_oh), 32'(e.oh));
          if (e.gap != 8'd0) check("wr_gap", 32'(cyc - last_cyc), 32'(e.gap));
        end
        last_cyc = cyc;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int t;
    rst       = 1'b0;
    buf_full  = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_grant", 32'(grant_oh), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_wr_en", 32'(fifo_wr_en), 32'h0);
    check("rst_ready", 32'(req_ready), 32'h0);
    rst = 1'b1;

    // Fairness: everyone valid, no last -> 0,1,2,3,0 with 8-beat bursts.
    @(posedge clk); #2;
    load(0, 16, 8'h00, 1'b0);
    load(1, 8, 8'h20, 1'b0);
    load(2, 8, 8'h40, 1'b0);
    load(3, 8, 8'h60, 1'b0);
    expect_run(0, 8, 8'h00, 0);
    expect_run(1, 8, 8'h20, 2);
    expect_run(2, 8, 8'h40, 2);
    expect_run(3, 8, 8'h60, 2);
    expect_run(0, 8, 8'h08, 2);
    update_drv();
    drain("fair");

    // Single packet from req0.
    @(posedge clk); #2;
    pq[0].push_back({1'b0, 8'h11});
    pq[0].push_back({1'b0, 8'h22});
    pq[0].push_back({1'b1, 8'h33});
    expect_run(0, 1, 8'h11, 0);
    expect_run(0, 1, 8'h22, 1);
    expect_run(0, 1, 8'h33, 1);
    update_drv();
    @(negedge clk);
    check("single_no_grant_yet", 32'(grant_oh), 32'h0);
    @(negedge clk);
    check("single_grant", 32'(grant_oh), 32'h1);
    check("single_busy", 32'(busy), 32'h1);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("single_grant_drop", 32'(grant_oh), 32'h0);
    check("single_busy_drop", 32'(busy), 32'h0);
    drain("single");

    // Backpressure: FIFO full for 5 cycles after beat 2 of a req2 burst.
    @(posedge clk); #2;
    base = n_wr;
    load(2, 8, 8'hA0, 1'b0);
    expect_run(2, 2, 8'hA0, 0);
    expect_run(2, 6, 8'hA2, 6);
    update_drv();
    wait_writes(base + 2, "bp");
    #1 buf_full = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_wr_en", 32'(fifo_wr_en), 32'h0);
      check("bp_ready", 32'(req_ready), 32'h0);
      check("bp_grant", 32'(grant_oh), 32'h4);
    end
    @(posedge clk);
    #1 buf_full = 1'b0;
    drain("bp");

    // Valid drop: req1 stalls after 3 beats, req2 waiting.
    @(posedge clk); #2;
    load(1, 3, 8'hB0, 1'b0);
    load(2, 2, 8'hC0, 1'b1);
    expect_run(1, 3, 8'hB0, 0);
    expect_run(2, 2, 8'hC0, 3);
    update_drv();
    drain("drop");

    // Reset abort at beat 3 of a req0 burst.
    @(posedge clk); #2;
    base = n_wr;
    load(0, 8, 8'hD0, 1'b0);
    load(1, 2, 8'hE0, 1'b1);
    expect_run(0, 3, 8'hD0, 0);
    expect_run(0, 5, 8'hD3, 0);
    expect_run(1, 2, 8'hE0, 3);
    update_drv();
    wait_writes(base + 3, "abort");
    #2 rst = 1'b0;
    #1;
    check("abort_grant", 32'(grant_oh), 32'h0);
    check("abort_wr_en", 32'(fifo_wr_en), 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_ready", 32'(req_ready), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (grant_oh == '0 && t < 10);
    check("abort_first_grant", 32'(grant_oh), 32'h1);
    drain("abort");

`ifdef FIFO_ARB_STATS_EN
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #2;
    load(3, 20, 8'h00, 1'b1);
    load(0, 5, 8'h80, 1'b1);
    expect_run(0, 5, 8'h80, 0);
    expect_run(3, 20, 8'h00, 0);
    update_drv();
    drain("stats");
    check("stat_req0", 32'(stat_cnt[0 +: 16]), 32'd5);
    check("stat_req1", 32'(stat_cnt[16 +: 16]), 32'd0);
    check("stat_req2", 32'(stat_cnt[32 +: 16]), 32'd0);
    check("stat_req3", 32'(stat_cnt[48 +: 16]), 32'd20);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
